// File: rtl/brisc_pkg.sv
// Shared types for the brisc core: instruction classes,
// major opcodes and decode-controller states.
package brisc_pkg;

  localparam int ILEN = 32;

  typedef enum logic [2:0] {
    IT_R,
    IT_I,
    IT_S,
    IT_B,
    IT_U,
    IT_J
  } itype_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    DC_RUN,
    DC_STALL,
    DC_TRAP
  } dctrl_state_e;

endpackage

// File: rtl/decode_ctrl_classifier.sv
// Opcode to format class, plus which source registers
// the class actually reads.
module opcode_classifier
  import brisc_pkg::*;
(
  input  logic [6:0] i_opcode,
  output itype_e     o_itype,
  output logic       o_uses_rs1,
  output logic       o_uses_rs2
);

  always_comb begin
    o_itype = IT_R;
    unique case (1'b1)
      (i_opcode == OPC_OP):
        o_itype = IT_R;
      (i_opcode == OPC_OP_IMM) ||
      (i_opcode == OPC_LOAD) ||
      (i_opcode == OPC_JALR):
        o_itype = IT_I;
      (i_opcode == OPC_STORE):
        o_itype = IT_S;
      (i_opcode == OPC_BRANCH):
        o_itype = IT_B;
      (i_opcode == OPC_LUI) ||
      (i_opcode == OPC_AUIPC):
        o_itype = IT_U;
      (i_opcode == OPC_JAL):
        o_itype = IT_J;
      default:
        o_itype = IT_R;
    endcase
  end

  always_comb begin
    o_uses_rs1 = (o_itype == IT_R) || (o_itype == IT_I) ||
                 (o_itype == IT_S) || (o_itype == IT_B);
    o_uses_rs2 = (o_itype == IT_R) || (o_itype == IT_S) ||
                 (o_itype == IT_B);
  end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage sequencer: IF/ID register, skid buffer,
// load-use bubbles, illegal-instruction trap, EX handshake.
module decode_ctrl
  import brisc_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int PC_W     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [ILEN-1:0] if_instr,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_ready,
  output logic [ILEN-1:0] dec_instr,
  output itype_e          dec_itype,
  input  logic            dec_i_valid,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  output logic            id_valid,
  output logic [PC_W-1:0] id_pc,
  input  logic            id_ready,
  input  logic            flush,
  output logic            illegal
);

  localparam int CW = $clog2(LOAD_LAT + 1);
  // The hazard cycle is itself the first bubble, so STALL
  // only covers the remaining LOAD_LAT-1 cycles.
  localparam bit STALL_EN = (LOAD_LAT > 1);
  localparam logic [CW-1:0] CNT_INIT =
    CW'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);

  dctrl_state_e    r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_id_valid;
  logic [ILEN-1:0] r_instr;
  logic [PC_W-1:0] r_pc;
  itype_e          r_itype;
  logic            r_use1;
  logic            r_use2;
  logic            r_sk_valid;
  logic [ILEN-1:0] r_sk_instr;
  logic [PC_W-1:0] r_sk_pc;

  logic            w_run;
  logic            w_hazard;
  logic            w_trap;
  logic            w_stall_go;
  logic            w_adv;
  logic            w_if_fire;
  logic            w_id_load;
  logic [ILEN-1:0] w_in_instr;
  logic [PC_W-1:0] w_in_pc;
  itype_e          w_in_itype;
  logic            w_in_use1;
  logic            w_in_use2;

  opcode_classifier u_cls (
    .i_opcode   (w_in_instr[6:0]),
    .o_itype    (w_in_itype),
    .o_uses_rs1 (w_in_use1),
    .o_uses_rs2 (w_in_use2)
  );

  assign w_in_instr = r_sk_valid ? r_sk_instr : if_instr;
  assign w_in_pc    = r_sk_valid ? r_sk_pc : if_pc;

  assign w_run    = (r_state == DC_RUN);
  assign w_hazard = ex_is_load && (ex_rd != 5'd0) &&
                    ((r_use1 && (dec_rs1 == ex_rd)) ||
                     (r_use2 && (dec_rs2 == ex_rd)));

  assign w_trap     = w_run && r_id_valid && !dec_i_valid;
  assign w_stall_go = w_run && r_id_valid && dec_i_valid &&
                      w_hazard;

  assign id_valid = w_run && r_id_valid && dec_i_valid &&
                    !w_hazard;
  assign illegal  = w_trap && !flush;
  assign if_ready = !r_sk_valid && (r_state != DC_TRAP) &&
                    !flush;

  assign w_adv     = id_valid && id_ready;
  assign w_if_fire = if_valid && if_ready;
  assign w_id_load = !r_id_valid || w_adv;

  assign dec_instr = r_instr;
  assign dec_itype = r_itype;
  assign id_pc     = r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= DC_RUN;
      r_cnt      <= '0;
      r_id_valid <= 1'b0;
      r_instr    <= '0;
      r_pc       <= '0;
      r_itype    <= IT_R;
      r_use1     <= 1'b0;
      r_use2     <= 1'b0;
      r_sk_valid <= 1'b0;
      r_sk_instr <= '0;
      r_sk_pc    <= '0;
    end else if (flush) begin
      r_state    <= DC_RUN;
      r_cnt      <= '0;
      r_id_valid <= 1'b0;
      r_sk_valid <= 1'b0;
    end else begin
      unique case (r_state)
        DC_RUN: begin
          if (w_trap) begin
            r_state <= DC_TRAP;
          end else if (w_stall_go && STALL_EN) begin
            r_state <= DC_STALL;
            r_cnt   <= CNT_INIT;
          end
        end
        DC_STALL: begin
          if (r_cnt == '0) r_state <= DC_RUN;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        DC_TRAP: r_state <= DC_TRAP;
        default: r_state <= DC_RUN;
      endcase

      if (w_id_load) begin
        if (r_sk_valid || w_if_fire) begin
          r_id_valid <= 1'b1;
          r_instr    <= w_in_instr;
          r_pc       <= w_in_pc;
          r_itype    <= w_in_itype;
          r_use1     <= w_in_use1;
          r_use2     <= w_in_use2;
          r_sk_valid <= 1'b0;
        end else begin
          r_id_valid <= 1'b0;
        end
      end else if (w_if_fire) begin
        r_sk_valid <= 1'b1;
        r_sk_instr <= if_instr;
        r_sk_pc    <= if_pc;
      end
    end
  end

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl; two instances share
// stimulus, LOAD_LAT=1 (u1) and LOAD_LAT=3 (u3).
module tb_decode_ctrl;
  import brisc_pkg::*;

  localparam logic [31:0] I_ADD  = 32'h002280B3;
  localparam logic [31:0] I_ADDI = 32'h00108193;
  localparam logic [31:0] I_ADD5 = 32'h00500193;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        id_ready;
  logic        flush;

  logic        r1_ifr, r3_ifr;
  logic [31:0] d1_instr, d3_instr;
  itype_e      d1_ty, d3_ty;
  logic        d1_ok, d3_ok;
  logic        v1, v3;
  logic [31:0] pc1, pc3;
  logic        ill1, ill3;

  int errors = 0;
  int checks = 0;

  function automatic logic dec_ok(input logic [31:0] ins);
    case (ins[6:0])
      OPC_OP, OPC_OP_IMM, OPC_LOAD,
      OPC_JALR, OPC_STORE, OPC_BRANCH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign d1_ok = dec_ok(d1_instr);
  assign d3_ok = dec_ok(d3_instr);

  decode_ctrl #(.LOAD_LAT(1), .PC_W(32)) u1 (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_ready(r1_ifr),
    .dec_instr(d1_instr), .dec_itype(d1_ty),
    .dec_i_valid(d1_ok),
    .dec_rs1(d1_instr[19:15]), .dec_rs2(d1_instr[24:20]),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .id_valid(v1), .id_pc(pc1), .id_ready(id_ready),
    .flush(flush), .illegal(ill1)
  );

  decode_ctrl #(.LOAD_LAT(3), .PC_W(32)) u3 (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_ready(r3_ifr),
    .dec_instr(d3_instr), .dec_itype(d3_ty),
    .dec_i_valid(d3_ok),
    .dec_rs1(d3_instr[19:15]), .dec_rs2(d3_instr[24:20]),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .id_valid(v3), .id_pc(pc3), .id_ready(id_ready),
    .flush(flush), .illegal(ill3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_valid = 0; ex_is_load = 0; ex_rd = 0;
    id_ready = 1; flush = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (r1_ifr !== 1'b1 || v1 !== 1'b0 || ill1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: ifr=%b v=%b ill=%b want 1 0 0",
               r1_ifr, v1, ill1);
    end
    checks++;
    if (pc1 !== 32'h0 || d1_instr !== 32'h0 || d1_ty !== IT_R) begin
      errors++;
      $display("FAIL reset_data: pc=%h instr=%h ty=%0d want 0 0 R",
               pc1, d1_instr, d1_ty);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] ins [4];
    itype_e ty [4];
    ins = '{I_ADD, I_ADDI, I_SW, I_BEQ};
    ty  = '{IT_R, IT_I, IT_S, IT_B};
    id_ready = 1;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        if_valid = 1; if_instr = ins[i];
        if_pc = 32'h100 + 32'(4 * i);
      end else begin
        if_valid = 0;
      end
      #1;
      if (i == 0) begin
        checks++;
        if (r1_ifr !== 1'b1) begin
          errors++;
          $display("FAIL stream_ifr: got %b want 1", r1_ifr);
        end
      end else begin
        checks++;
        if (v1 !== 1'b1 || pc1 !== 32'h100 + 32'(4 * (i - 1)) ||
            d1_ty !== ty[i-1]) begin
          errors++;
          $display("FAIL stream_%0d: v=%b pc=%h ty=%0d want 1 %h %0d",
                   i, v1, pc1, d1_ty, 32'h100 + 32'(4 * (i - 1)),
                   ty[i-1]);
        end
      end
      tick();
    end
    #1;
    checks++;
    if (v1 !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: v=%b want 0", v1);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] ins [3];
    logic [4:0]  rd [3];
    logic        bub [3];
    ins = '{I_ADD, I_ADD, I_ADD5};
    rd  = '{5'd5, 5'd0, 5'd5};
    bub = '{1'b1, 1'b0, 1'b0};
    id_ready = 1;
    for (int k = 0; k < 3; k++) begin
      if_valid = 1; if_instr = ins[k];
      if_pc = 32'h200 + 32'(4 * k);
      tick();
      if_valid = 0; ex_is_load = 1; ex_rd = rd[k];
      #1;
      checks++;
      if (v1 !== !bub[k]) begin
        errors++;
        $display("FAIL lu_first_%0d: v=%b want %b", k, v1, !bub[k]);
      end
      tick();
      ex_is_load = 0;
      if (bub[k]) begin
        #1;
        checks++;
        if (v1 !== 1'b1 || pc1 !== 32'h200 + 32'(4 * k)) begin
          errors++;
          $display("FAIL lu_after_%0d: v=%b pc=%h want 1 %h",
                   k, v1, pc1, 32'h200 + 32'(4 * k));
        end
        tick();
      end
      #1;
      checks++;
      if (v1 !== 1'b0) begin
        errors++;
        $display("FAIL lu_drain_%0d: v=%b want 0", k, v1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic exp_rdy [6];
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if_valid = 1; if_instr = I_ADD;
      if_pc = (c == 0) ? 32'h300 : (c == 1) ? 32'h304 : 32'h308;
      id_ready = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
      #1;
      checks++;
      if (r1_ifr !== exp_rdy[c]) begin
        errors++;
        $display("FAIL bp_ifr_%0d: got %b want %b",
                 c, r1_ifr, exp_rdy[c]);
      end
      if (c >= 1) begin
        checks++;
        if (v1 !== 1'b1 ||
            pc1 !== ((c <= 4) ? 32'h300 : 32'h304)) begin
          errors++;
          $display("FAIL bp_out_%0d: v=%b pc=%h want 1 %h", c, v1,
                   pc1, (c <= 4) ? 32'h300 : 32'h304);
        end
      end
      tick();
    end
    if_valid = 0; #1;
    checks++;
    if (v1 !== 1'b1 || pc1 !== 32'h308) begin
      errors++;
      $display("FAIL bp_third: v=%b pc=%h want 1 308", v1, pc1);
    end
    tick(); #1;
    checks++;
    if (v1 !== 1'b0) begin
      errors++;
      $display("FAIL bp_nodup: v=%b want 0", v1);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    if_valid = 1; if_instr = I_BAD; if_pc = 32'h400;
    tick();
    if_valid = 0; #1;
    checks++;
    if (ill1 !== 1'b1 || v1 !== 1'b0) begin
      errors++;
      $display("FAIL ill_entry: ill=%b v=%b want 1 0", ill1, v1);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if_valid = (c == 2); if_instr = I_ADD; if_pc = 32'h404;
      #1;
      checks++;
      if (ill1 !== 1'b0 || v1 !== 1'b0 || r1_ifr !== 1'b0) begin
        errors++;
        $display("FAIL ill_hold_%0d: ill=%b v=%b ifr=%b want 0 0 0",
                 c, ill1, v1, r1_ifr);
      end
    end
    flush = 1;
    tick();
    flush = 0; if_valid = 1; if_instr = I_ADD; if_pc = 32'h410;
    #1;
    checks++;
    if (r1_ifr !== 1'b1 || v1 !== 1'b0 || ill1 !== 1'b0) begin
      errors++;
      $display("FAIL ill_flush: ifr=%b v=%b ill=%b want 1 0 0",
               r1_ifr, v1, ill1);
    end
    tick();
    if_valid = 0; #1;
    checks++;
    if (v1 !== 1'b1 || pc1 !== 32'h410) begin
      errors++;
      $display("FAIL ill_resume: v=%b pc=%h want 1 410", v1, pc1);
    end
    tick();
  endtask

  task automatic test_flush_skid();
    do_reset();
    id_ready = 0;
    if_valid = 1; if_instr = I_ADD; if_pc = 32'h500;
    tick();
    if_pc = 32'h504;
    tick();
    if_pc = 32'h508; flush = 1; #1;
    checks++;
    if (r1_ifr !== 1'b0) begin
      errors++;
      $display("FAIL fl_ifr: got %b want 0", r1_ifr);
    end
    tick();
    flush = 0; if_valid = 0; id_ready = 1; #1;
    checks++;
    if (v1 !== 1'b0 || r1_ifr !== 1'b1) begin
      errors++;
      $display("FAIL fl_clear: v=%b ifr=%b want 0 1", v1, r1_ifr);
    end
    tick(); #1;
    checks++;
    if (v1 !== 1'b0) begin
      errors++;
      $display("FAIL fl_noaccept: v=%b pc=%h want 0", v1, pc1);
    end
  endtask

  task automatic test_stall_lat3();
    logic exp_v [4];
    exp_v = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    if_valid = 1; if_instr = I_ADD; if_pc = 32'h580;
    tick();
    if_valid = 0;
    for (int c = 0; c < 4; c++) begin
      ex_is_load = (c == 0); ex_rd = 5'd5;
      #1;
      checks++;
      if (v3 !== exp_v[c]) begin
        errors++;
        $display("FAIL stall3_%0d: v=%b want %b", c, v3, exp_v[c]);
      end
      tick();
    end
    #1;
    checks++;
    if (v3 !== 1'b0) begin
      errors++;
      $display("FAIL stall3_drain: v=%b want 0", v3);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    if_valid = 1; if_instr = I_ADD; if_pc = 32'h600;
    tick();
    if_valid = 0; ex_is_load = 1; ex_rd = 5'd5;
    tick();
    ex_is_load = 0; #1;
    checks++;
    if (v3 !== 1'b0) begin
      errors++;
      $display("FAIL rst3_stall: v=%b want 0", v3);
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if (r3_ifr !== 1'b1 || v3 !== 1'b0 || ill3 !== 1'b0 ||
        pc3 !== 32'h0 || d3_instr !== 32'h0 || d3_ty !== IT_R) begin
      errors++;
      $display("FAIL rst3_async: ifr=%b v=%b ill=%b pc=%h ins=%h",
               r3_ifr, v3, ill3, pc3, d3_instr);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    if_valid = 1; if_instr = I_ADD; if_pc = 32'h700;
    tick();
    if_valid = 0; #1;
    checks++;
    if (v3 !== 1'b1 || pc3 !== 32'h700) begin
      errors++;
      $display("FAIL rst3_after: v=%b pc=%h want 1 700", v3, pc3);
    end
    tick();
  endtask

  initial begin
    rst_n = 0; if_valid = 0; if_instr = '0; if_pc = '0;
    ex_is_load = 0; ex_rd = '0; id_ready = 1; flush = 0;
    test_reset();
    test_stream();
    test_load_use();
    test_backpressure();
    test_illegal();
    test_flush_skid();
    test_stall_lat3();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
